// File: rtl/ad9970_pkg.sv
// Shared constants, state encoding and width helper for the AD9970 serial-lane emulator.
package ad9970_pkg;

    localparam string SerFirstLsb = "LSB";
    localparam string SerFirstMsb = "MSB";
    localparam string EndLittle   = "LITTLE";
    localparam string EndBig      = "BIG";

    typedef enum logic [0:0] {
        StTrain = 1'b0,
        StData  = 1'b1
    } ser_state_e;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/ad9970_ser_emu_if.sv
// Parallel-word source / serial-lane bundle between a data source and the emulator.
interface ad9970_ser_emu_if #(
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned DESER_WIDTH = 6
);
    logic [CHANNEL_NUM*DESER_WIDTH-1:0] iv_data;
    logic                               i_data_valid;
    logic                               o_data_ready;
    logic                               i_train_req;
    logic [CHANNEL_NUM-1:0]             ov_ser_data;
    logic                               o_word_start;
    logic                               o_training;

    modport master (
        output iv_data, i_data_valid, i_train_req,
        input  o_data_ready, ov_ser_data, o_word_start, o_training
    );

    modport slave (
        input  iv_data, i_data_valid, i_train_req,
        output o_data_ready, ov_ser_data, o_word_start, o_training
    );
endinterface

// File: rtl/ad9970_ser_lane.sv
// One serial lane: loads a word at a boundary and shifts it out one bit per clock.
module ad9970_ser_lane #(
    parameter int unsigned DESER_WIDTH = 6,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [DESER_WIDTH-1:0] word_i,
    output logic                   ser_o
);

    // sr_q holds the bits still to be sent after the one currently on ser_q.
    logic [DESER_WIDTH-1:0] sr_q, sr_d;
    logic                   ser_q, ser_d;

    always_comb begin
        sr_d  = sr_q;
        ser_d = ser_q;
        if (load_i) begin
            if (MSB_FIRST) begin
                ser_d = word_i[DESER_WIDTH-1];
                sr_d  = word_i << 1;
            end else begin
                ser_d = word_i[0];
                sr_d  = word_i >> 1;
            end
        end else begin
            if (MSB_FIRST) begin
                ser_d = sr_q[DESER_WIDTH-1];
                sr_d  = sr_q << 1;
            end else begin
                ser_d = sr_q[0];
                sr_d  = sr_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q  <= '0;
            ser_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            ser_q <= ser_d;
        end
    end

    assign ser_o = ser_q;

endmodule

// File: rtl/ad9970_ser_emu.sv
// AD9970 LVDS lane emulator: training bursts, then handshaked parallel words serialised per lane.
module ad9970_ser_emu
    import ad9970_pkg::*;
#(
    parameter string                  SER_FIRST_BIT = "LSB",
    parameter string                  END_STYLE     = "LITTLE",
    parameter int unsigned            CHANNEL_NUM   = 4,
    parameter int unsigned            DESER_WIDTH   = 6,
    parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 6'b000111,
    parameter int unsigned            TRAIN_WORDS   = 16,
    parameter logic [DESER_WIDTH-1:0] IDLE_WORD     = 6'b000000
) (
    input logic                clk,
    input logic                reset,
    ad9970_ser_emu_if.slave    bus
);

    localparam int unsigned BitCntW   = clog2(DESER_WIDTH);
    localparam int unsigned TrainCntW = clog2(TRAIN_WORDS + 1);
    localparam logic [BitCntW-1:0]   LastBit   = BitCntW'(DESER_WIDTH - 1);
    localparam logic [TrainCntW-1:0] TrainLast = TrainCntW'(TRAIN_WORDS);
    localparam bit MsbFirst = (SER_FIRST_BIT == SerFirstMsb);
    localparam bit BigEnd   = (END_STYLE == EndBig);

    ser_state_e             state_q;
    logic [BitCntW-1:0]     bit_cnt_q;
    logic [TrainCntW-1:0]   train_cnt_q;
    logic                   train_pend_q;
    logic                   word_start_q;
    logic                   training_q;

    logic                   boundary;
    logic                   pend_now;
    logic                   ready;
    logic                   accept;
    logic                   train_load;
    logic [TrainCntW-1:0]   train_cnt_inc;
    logic [CHANNEL_NUM-1:0] ser;

    assign boundary   = (bit_cnt_q == LastBit);
    assign pend_now   = train_pend_q | bus.i_train_req;
    assign ready      = !reset && (state_q == StData) && boundary && !train_pend_q;
    // A training request landing on the boundary wins over a word accepted in that cycle.
    assign accept     = bus.i_data_valid && ready && !bus.i_train_req;
    assign train_load = pend_now || (state_q == StTrain);

    always_comb begin
        train_cnt_inc = (pend_now ? TrainCntW'(0) : train_cnt_q) + TrainCntW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StTrain;
            bit_cnt_q    <= LastBit;
            train_cnt_q  <= '0;
            train_pend_q <= 1'b0;
            word_start_q <= 1'b0;
            training_q   <= 1'b0;
        end else if (boundary) begin
            bit_cnt_q    <= '0;
            word_start_q <= 1'b1;
            training_q   <= train_load;
            train_pend_q <= 1'b0;
            if (train_load) begin
                if (train_cnt_inc == TrainLast) begin
                    state_q     <= StData;
                    train_cnt_q <= '0;
                end else begin
                    state_q     <= StTrain;
                    train_cnt_q <= train_cnt_inc;
                end
            end
        end else begin
            bit_cnt_q    <= bit_cnt_q + BitCntW'(1);
            word_start_q <= 1'b0;
            train_pend_q <= pend_now;
        end
    end

    for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_lane
        localparam int Slice = BigEnd ? (int'(CHANNEL_NUM) - 1 - k) : k;
        logic [DESER_WIDTH-1:0] word;

        always_comb begin
            word = IDLE_WORD;
            if (train_load) begin
                word = TRAIN_PATTERN;
            end else if (accept) begin
                word = bus.iv_data[Slice*DESER_WIDTH +: DESER_WIDTH];
            end
        end

        ad9970_ser_lane #(
            .DESER_WIDTH (DESER_WIDTH),
            .MSB_FIRST   (MsbFirst)
        ) u_lane (
            .clk_i   (clk),
            .reset_i (reset),
            .load_i  (boundary),
            .word_i  (word),
            .ser_o   (ser[k])
        );
    end

    assign bus.o_data_ready = ready;
    assign bus.ov_ser_data  = ser;
    assign bus.o_word_start = word_start_q;
    assign bus.o_training   = training_q;

endmodule

// File: tb/tb_ad9970_ser_emu.sv
// Bench for ad9970_ser_emu: word-level reference model plus directed literal checks on three builds.
module tb_ad9970_ser_emu;

    localparam int unsigned C  = 4;
    localparam int unsigned W  = 6;
    localparam int unsigned TW = 16;
    localparam logic [W-1:0] Pat  = 6'b000111;
    localparam logic [W-1:0] Idle = 6'b000000;

    logic         clk = 1'b0;
    logic         reset;
    logic [C*W-1:0] data;
    logic         valid;
    logic         req;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ad9970_ser_emu_if #(.CHANNEL_NUM(C), .DESER_WIDTH(W)) if0 ();
    ad9970_ser_emu_if #(.CHANNEL_NUM(C), .DESER_WIDTH(W)) if1 ();
    ad9970_ser_emu_if #(.CHANNEL_NUM(C), .DESER_WIDTH(W)) if2 ();

    assign if0.iv_data = data;  assign if0.i_data_valid = valid;  assign if0.i_train_req = req;
    assign if1.iv_data = data;  assign if1.i_data_valid = valid;  assign if1.i_train_req = req;
    assign if2.iv_data = data;  assign if2.i_data_valid = valid;  assign if2.i_train_req = req;

    ad9970_ser_emu #(.SER_FIRST_BIT("LSB"), .END_STYLE("LITTLE")) u_dut_lsb (
        .clk (clk), .reset (reset), .bus (if0)
    );
    ad9970_ser_emu #(.SER_FIRST_BIT("MSB"), .END_STYLE("LITTLE")) u_dut_msb (
        .clk (clk), .reset (reset), .bus (if1)
    );
    ad9970_ser_emu #(.SER_FIRST_BIT("LSB"), .END_STYLE("BIG")) u_dut_big (
        .clk (clk), .reset (reset), .bus (if2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: which word is on the wire, and how far into it we are.
    logic [W-1:0] m_wl [C];
    logic [W-1:0] m_wb [C];
    int m_pos, m_left;
    bit m_train, m_pend, m_have, m_tr, m_init = 1'b0;

    always @(posedge clk) begin : model
        bit rdy, pend_now, acc;
        if (reset) begin
            m_pos   = W - 1;
            m_train = 1'b1;
            m_left  = TW;
            m_pend  = 1'b0;
            m_have  = 1'b0;
            m_tr    = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            rdy      = !m_train && (m_pos == W - 1) && !m_pend;
            pend_now = m_pend || req;
            if (m_pos == W - 1) begin
                acc = valid && rdy && !pend_now;
                if (pend_now) begin
                    m_train = 1'b1;
                    m_left  = TW;
                    m_pend  = 1'b0;
                end
                for (int k = 0; k < C; k++) begin
                    if (m_train) begin
                        m_wl[k] = Pat;
                        m_wb[k] = Pat;
                    end else if (acc) begin
                        m_wl[k] = data[k*W +: W];
                        m_wb[k] = data[(C-1-k)*W +: W];
                    end else begin
                        m_wl[k] = Idle;
                        m_wb[k] = Idle;
                    end
                end
                m_tr = m_train;
                if (m_train) begin
                    m_left--;
                    if (m_left == 0) m_train = 1'b0;
                end
                m_pos  = 0;
                m_have = 1'b1;
            end else begin
                m_pos++;
                m_pend = pend_now;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [C-1:0] e0, e1, e2;
        bit er;
        #1;
        if (m_init) begin
            for (int k = 0; k < C; k++) begin
                e0[k] = m_have ? m_wl[k][m_pos]       : 1'b0;
                e1[k] = m_have ? m_wl[k][W-1-m_pos]   : 1'b0;
                e2[k] = m_have ? m_wb[k][m_pos]       : 1'b0;
            end
            er = !reset && !m_train && (m_pos == W - 1) && !m_pend;
            check("lsb ser", if0.ov_ser_data, e0);
            check("msb ser", if1.ov_ser_data, e1);
            check("big ser", if2.ov_ser_data, e2);
            check("word_start", if0.o_word_start, m_have && (m_pos == 0));
            check("training", if0.o_training, m_have && m_tr);
            check("ready", if0.o_data_ready, er);
            check("ready big", if2.o_data_ready, er);
        end
    end

    // Releases reset and checks the power-up training burst literally.
    task automatic release_and_train(input string tag);
        logic [W-1:0] w;
        int k, n_tr;
        @(negedge clk);
        reset = 1'b0;
        w = '0;
        n_tr = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            w[i] = if0.ov_ser_data[0];
        end
        check({tag, " first training word lane0"}, w, Pat);
        k = W;
        while (!if0.o_data_ready && k < 400) begin
            @(negedge clk);
            k++;
            if (if0.o_word_start && if0.o_training) n_tr++;
        end
        check({tag, " first ready cycle"}, k, 96);
        check({tag, " training word starts after first"}, n_tr, TW - 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] wl [C];
        logic [W-1:0] wm [C];
        logic [W-1:0] wb [C];
        int k, n, ws_cnt;
        bit restarted;
        logic [C-1:0] ser_or;

        data  = '0;
        valid = 1'b0;
        req   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ser", if0.ov_ser_data, 0);
        check("reset word_start", if0.o_word_start, 0);
        check("reset training", if0.o_training, 0);
        check("reset ready", if0.o_data_ready, 0);

        release_and_train("pwr");

        // Accept one word at the first ready.
        data  = {6'h11, 6'h22, 6'h0C, 6'h2A};
        valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
            for (int l = 0; l < C; l++) begin
                wl[l][i]     = if0.ov_ser_data[l];
                wm[l][W-1-i] = if1.ov_ser_data[l];
                wb[l][i]     = if2.ov_ser_data[l];
            end
        end
        check("lsb lane0", wl[0], 6'h2A);
        check("lsb lane3", wl[3], 6'h11);
        check("msb lane0", wm[0], 6'h2A);
        check("msb lane1", wm[1], 6'h0C);
        check("big lane0", wb[0], 6'h11);
        check("big lane1", wb[1], 6'h22);
        check("big lane2", wb[2], 6'h0C);
        check("big lane3", wb[3], 6'h2A);

        // Idle words keep the word cadence.
        ws_cnt = 0;
        ser_or = '0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            ws_cnt += int'(if0.o_word_start);
            ser_or |= if0.ov_ser_data;
        end
        check("idle word_start count", ws_cnt, 2);
        check("idle lanes", ser_or, 0);

        // Valid raised mid-word waits for the boundary.
        @(negedge clk);
        data  = 24'hFC003F;
        valid = 1'b1;
        k = 0;
        while (!if0.o_data_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid-word valid wait", k, W - 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
            for (int l = 0; l < C; l++) begin
                wl[l][i] = if0.ov_ser_data[l];
                wb[l][i] = if2.ov_ser_data[l];
            end
        end
        check("fc003f lsb lane0", wl[0], 6'h3F);
        check("fc003f lsb lane1", wl[1], 6'h00);
        check("fc003f big lane0", wb[0], 6'h3F);
        check("fc003f big lane2", wb[2], 6'h00);

        // Training request at bit 2 of a word.
        @(negedge clk);
        check("word start before req", if0.o_word_start, 1);
        repeat (2) @(negedge clk);
        req = 1'b1;
        k = 0;
        n = 0;
        while (!if0.o_data_ready && k < 400) begin
            @(negedge clk);
            req = 1'b0;
            k++;
            if (if0.o_word_start && if0.o_training) n++;
        end
        check("req latency to ready", k, 99);
        check("req burst words", n, TW);

        // Request on the boundary flushes the offered word; second request restarts the burst.
        data  = 24'h555555;
        valid = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        valid = 1'b0;
        check("flush training", if0.o_training, 1);
        n = 0;
        k = 0;
        restarted = 1'b0;
        while (!if0.o_data_ready && k < 1000) begin
            if (if0.o_word_start && if0.o_training) begin
                n++;
                if (n == 5 && !restarted) begin
                    req = 1'b1;
                    restarted = 1'b1;
                end
            end
            @(negedge clk);
            req = 1'b0;
            k++;
        end
        check("restarted burst words", n, 5 + TW);
        check("ready after restart", if0.o_data_ready, 1);

        // Reset at bit 3 of a data word.
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid-word reset ser", if0.ov_ser_data, 0);
        check("mid-word reset word_start", if0.o_word_start, 0);
        release_and_train("rst");

        repeat (8) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9970_ser_emu.md
Name: ad9970_ser_emu

Overview:
- Parallel-to-serial transmitter that emulates the AD9970 LVDS data lanes. It is the transmit-side counterpart of data_channel / deser_wrap.
- Takes one DESER_WIDTH-bit word per channel and shifts it out one bit per clk per lane (fabric SDR).
- A training-pattern phase lets the receiver run its bitslip/phase alignment.
- Used in loopback self-test and as a sensor stand-in on boards without the AFE.

Parameters:
- SER_FIRST_BIT, "LSB": "LSB" or "MSB", the bit of each word transmitted first.
- END_STYLE, "LITTLE": "LITTLE" puts channel 0 at iv_data[DESER_WIDTH-1:0]; "BIG" puts channel 0 at the top slice.
- CHANNEL_NUM, 4: number of serial lanes.
- DESER_WIDTH, 6: bits per word per lane, minimum 2.
- TRAIN_PATTERN, 6'b000111: training word, DESER_WIDTH bits, same on every lane.
- TRAIN_WORDS, 16: training words per training burst, 1..255.
- IDLE_WORD, 6'b000000: word sent when data is not supplied.

Ports:
- clk  in  1  serial bit clock, one bit per lane per cycle.
- reset  in  1  synchronous, active-high.
- iv_data  in  CHANNEL_NUM*DESER_WIDTH  parallel words, one per lane.
- i_data_valid  in  1  iv_data holds a word to send.
- o_data_ready  out  1  block accepts iv_data this cycle.
- i_train_req  in  1  single-cycle pulse requesting a training burst.
- ov_ser_data  out  CHANNEL_NUM  serial bit per lane.
- o_word_start  out  1  ov_ser_data carries bit 0 of a word.
- o_training  out  1  the current word is the training pattern.

Behaviour:
- Clocking and reset: single clock clk. reset is synchronous, active-high.
- Reset values: all outputs 0. State=TRAIN, bit_cnt=DESER_WIDTH-1, train_cnt=0, train_pend=0, all shift registers 0.
- bit_cnt counts 0..DESER_WIDTH-1 and wraps. A word boundary occurs when bit_cnt==DESER_WIDTH-1.
- At a boundary the next word is loaded into every lane's shift register and bit_cnt becomes 0. On other cycles the registers shift toward the output, in the direction set by SER_FIRST_BIT.
- ov_ser_data, o_word_start and o_training are registered. They are updated on the same edge that loads or shifts.
- o_word_start=1 only on the cycle after a load.
- States:
  - TRAIN: each boundary loads TRAIN_PATTERN on all lanes, sets o_training=1 and increments train_cnt. When the load makes train_cnt==TRAIN_WORDS, go to DATA and clear train_cnt.
  - DATA: each boundary loads either iv_data (if i_data_valid && o_data_ready) or IDLE_WORD. o_training=0.
- Timing:
  - The first edge after reset release loads training word 1, so its bit 0 is on the output one cycle after release.
  - Each training burst lasts exactly TRAIN_WORDS*DESER_WIDTH cycles.
- o_data_ready is combinational from registers: (state==DATA && bit_cnt==DESER_WIDTH-1 && !train_pend). It is 0 during reset.
- Handshake:
  - A word is accepted only when valid and ready are both high in the same cycle.
  - The accepted word's bit 0 appears on the next cycle. Latency from acceptance to first bit is 1 cycle.
  - No buffering: valid without ready is ignored, and the source holds its word.
- i_train_req:
  - Sets train_pend. The current word always completes.
  - At the next boundary with train_pend=1: go to or stay in TRAIN, clear train_pend, set train_cnt=0, and load TRAIN_PATTERN. An in-progress burst therefore restarts with a full TRAIN_WORDS.
  - i_train_req on the boundary cycle itself takes effect at that boundary. o_data_ready is then still high, but the accepted word is dropped in favour of training. Sources must treat i_train_req as flushing.
- Lane mapping: lane k of iv_data is slice k (LITTLE) or slice CHANNEL_NUM-1-k (BIG). Training and idle words are identical on all lanes.
- Reset mid-word: outputs are 0 on the next edge, and the sequence restarts from TRAIN exactly as at power-up.

Decomposition:
- Shared package (ad9970_pkg): SER_FIRST_BIT and END_STYLE string constants, state encoding (TRAIN=0, DATA=1), and a clog2 function for the bit_cnt and train_cnt widths.
- One sub-module: ad9970_ser_lane, one per channel via generate. It contains the shift register with load/shift and SER_FIRST_BIT handling.
- The top holds the FSM, the counters, the handshake and the END_STYLE slicing.

Test Plan:
- Reset release with defaults and LSB: each lane shows 1,1,1,0,0,0 repeated 16 times (96 cycles). o_word_start pulses every 6 cycles and o_training=1 throughout. o_data_ready first asserts at cycle 96.
- After training, iv_data lane0=6'h2A with valid held high: accepted at the first ready, then lane0 shows 0,1,0,1,0,1 starting the next cycle. With SER_FIRST_BIT="MSB": 1,0,1,0,1,0.
- END_STYLE="BIG" with iv_data=24'hFC0_03F (lane slices 3F,00,00,3F under LITTLE) and distinct per-slice values: lane 0 carries the top slice. Check all 4 lanes bitwise.
- i_data_valid=0 in DATA: lanes carry IDLE_WORD (all 0) and o_word_start keeps a 6-cycle cadence. Valid asserted mid-word is accepted only at bit_cnt==5.
- i_train_req at bit_cnt==2 of a data word: that word finishes, then exactly 16 training words, then ready returns. A second req during the burst restarts the count at the next boundary, giving 16 more words.
- reset asserted at bit_cnt==3: the next cycle has ov_ser_data=0 and o_word_start=0. After release the power-up training sequence repeats exactly.
